uart_operand_rx: RTL
====================

// Module: uart_operand_rx
// PURPOSE
//  UART receive side of the adder test harness. Deserialises 8-bit frames from the serial rx line,
//  assembles 17-byte command packets (1 opcode + two 64-bit operands), and presents op_sel/op_a/op_b
//  with a one-cycle op_valid strobe. These outputs feed the adder-select top level (its state and
//  data_in1/data_in2 inputs). It is the receive-direction counterpart of that top level's tx path.
// PARAMETERS
//  CLK_HZ      100_000_000  system clock frequency, Hz
//  BAUD        115_200      serial bit rate
//  OVERSAMPLE  16           sample ticks per bit; DIV = CLK_HZ/(BAUD*OVERSAMPLE), integer-truncated (54 at defaults)
// PORTS
//  clk        in   1   system clock, all logic on rising edge
//  rst        in   1   reset: synchronous, active-high
//  rx         in   1   asynchronous serial input, idle high, 8 data bits LSB first, 1 stop bit
//  op_valid   out  1   one-cycle pulse: complete packet received, op_* updated this cycle
//  op_sel     out  2   adder select from opcode byte bits[1:0]
//  op_a       out  64  operand A, little-endian (packet bytes 1..8)
//  op_b       out  64  operand B, little-endian (packet bytes 9..16)
//  frame_err  out  1   one-cycle pulse: stop bit (or parity, see CONFIGURATION) sampled bad
//  busy       out  1   high while a frame or a partial packet is in progress
// BEHAVIOUR
//  - Reset: op_valid=0, frame_err=0, busy=0, op_sel=0, op_a=0, op_b=0; FSM=IDLE; byte_cnt=0.
//    Synchroniser flops reset to 1. Reset mid-frame or mid-packet discards everything with no pulse.
//  - rx passes through a 2-flop synchroniser. Internal sample tick fires every DIV clocks; the tick
//    counter is held at 0 while the FSM is in IDLE.
//  - Frame FSM:
//    IDLE  -> START on a synchronised falling edge; the tick-phase counter clears.
//    START -> samples at tick 7 (mid-bit). rx=1 there is a glitch: return to IDLE, no error.
//             rx=0 there: go to DATA.
//    DATA  -> samples every 16 ticks, LSB first. After 8 bits go to PARITY if the parity option
//             is compiled in, otherwise go to STOP.
//    STOP  -> samples at mid-bit. rx=1: byte accepted. rx=0: frame_err pulses and the byte is
//             dropped. In both cases return to IDLE immediately, so back-to-back frames are accepted.
//  - Packet assembler, driven by byte_cnt 0..16:
//    byte 0 = opcode; it must match 8'b101000ss. Otherwise the byte is silently discarded and
//             byte_cnt stays 0 (resync).
//    bytes 1..8 go into shadow A[8k-1:8k-8]; bytes 9..16 go into shadow B in the same order.
//  - On acceptance of byte 16: op_sel/op_a/op_b load from shadow and op_valid=1 on the next clk
//    edge (latency 1 clk after the stop-bit mid-sample); byte_cnt returns to 0.
//  - Outputs hold their value until the next op_valid. Partial packets never alter op_*.
//  - frame_err at any byte_cnt aborts the packet: byte_cnt=0, shadow contents are don't-care.
//  - busy = (FSM!=IDLE) | (byte_cnt!=0).
//  - op_valid and frame_err are mutually exclusive and are never asserted for 2 consecutive cycles.
// CONFIGURATION
//  UART_RX_PARITY_EN defined:
//    - An even-parity bit follows the data bits.
//    - Parity mismatch at mid-bit pulses frame_err together with the STOP check result and aborts
//      the packet exactly like a bad stop bit.
//    - Frame length is 11 bits.
//  UART_RX_PARITY_EN undefined:
//    - No PARITY state; frame is 10 bits.
//    - A parity bit sent by a transmitter is sampled as the stop bit.
// TESTING
//  - Run the bench at defaults, so 1 bit = 864 clk. Bench serialiser is 8N1 unless stated otherwise.
//  1 Reset, rx idle for 2000 clk -> all outputs 0, busy=0, no pulses.
//  2 Send A1, 01 02 03 04 05 06 07 08, FF x8 -> exactly one op_valid with op_sel=1,
//    op_a=64'h0807060504030201, op_b=64'hFFFF_FFFF_FFFF_FFFF, within 1 clk of the last stop mid-sample.
//  3 Send byte 55 then a valid packet with opcode A2 -> 55 ignored; op_valid with op_sel=2;
//    no frame_err.
//  4 Valid packet with byte 5's stop bit forced low -> frame_err pulse, no op_valid. Then a fresh
//    packet (A0, all 00) -> op_valid, op_sel=0, op_a=op_b=0.
//  5 rx low pulse of 300 clk while idle -> no error, no byte, busy back to 0 within 1 bit time.
//  6 Assert rst mid-byte 10, then send a full valid packet -> op_valid only for the new packet;
//    op_* unchanged before it.
//    Repeat with UART_RX_PARITY_EN defined, a bad parity bit on byte 3 -> frame_err, packet aborted.

Source files
------------

// File: rtl/uart_operand_rx.sv
// UART receiver that assembles 17-byte opcode/operand packets for the adder-select top level.
// Optional build macro UART_RX_PARITY_EN adds an even-parity bit after the data bits (8E1).
module uart_operand_rx #(
    parameter int CLK_HZ     = 100_000_000,
    parameter int BAUD       = 115_200,
    parameter int OVERSAMPLE = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rx,
    output logic        op_valid,
    output logic [1:0]  op_sel,
    output logic [63:0] op_a,
    output logic [63:0] op_b,
    output logic        frame_err,
    output logic        busy
);
    localparam int DIV = CLK_HZ / (BAUD * OVERSAMPLE);
    localparam int DW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int PW  = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
    localparam logic [DW-1:0] DIV_LAST   = DW'(DIV - 1);
    localparam logic [PW-1:0] PHASE_LAST = PW'(OVERSAMPLE - 1);
    localparam logic [PW-1:0] PHASE_MID  = PW'(OVERSAMPLE / 2 - 1);

`ifdef UART_RX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

    state_t        state_r;
    logic          rx_meta_r;
    logic          rx_sync_r;
    logic          rx_prev_r;
    logic [DW-1:0] div_cnt_r;
    logic [PW-1:0] phase_r;
    logic [2:0]    bit_cnt_r;
    logic [7:0]    shift_r;
    logic [4:0]    byte_cnt_r;
    logic [1:0]    sel_sh_r;
    logic [63:0]   sh_a_r;
    logic [63:0]   sh_b_r;
    logic          tick_s;
    logic          sample_s;
    logic          stop_ok_s;

`ifdef UART_RX_PARITY_EN
    logic          par_bad_r;

    function automatic logic even_parity(input logic [7:0] d);
        return ^d;
    endfunction

    assign stop_ok_s = rx_sync_r & ~par_bad_r;
`else
    assign stop_ok_s = rx_sync_r;
`endif

    assign tick_s   = (state_r != IDLE) && (div_cnt_r == DIV_LAST);
    assign sample_s = tick_s && (phase_r == PHASE_MID);
    assign busy     = (state_r != IDLE) || (byte_cnt_r != 5'd0);

    // Two-flop synchroniser plus one delay stage for falling-edge detection; idles high.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta_r <= 1'b1;
            rx_sync_r <= 1'b1;
            rx_prev_r <= 1'b1;
        end else begin
            rx_meta_r <= rx;
            rx_sync_r <= rx_meta_r;
            rx_prev_r <= rx_sync_r;
        end
    end

    // Oversample tick divider and phase counter, parked at zero while idle.
    always_ff @(posedge clk) begin
        if (rst || (state_r == IDLE)) begin
            div_cnt_r <= '0;
            phase_r   <= '0;
        end else if (div_cnt_r == DIV_LAST) begin
            div_cnt_r <= '0;
            phase_r   <= (phase_r == PHASE_LAST) ? '0 : phase_r + 1'b1;
        end else begin
            div_cnt_r <= div_cnt_r + 1'b1;
            phase_r   <= phase_r;
        end
    end

    // Frame FSM with the packet assembler folded into the stop-bit decision.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= IDLE;
            bit_cnt_r  <= 3'd0;
            shift_r    <= 8'd0;
            byte_cnt_r <= 5'd0;
            sel_sh_r   <= 2'd0;
            sh_a_r     <= 64'd0;
            sh_b_r     <= 64'd0;
            op_valid   <= 1'b0;
            frame_err  <= 1'b0;
            op_sel     <= 2'd0;
            op_a       <= 64'd0;
            op_b       <= 64'd0;
`ifdef UART_RX_PARITY_EN
            par_bad_r  <= 1'b0;
`endif
        end else begin
            op_valid  <= 1'b0;
            frame_err <= 1'b0;
            case (state_r)
                IDLE: begin
                    bit_cnt_r <= 3'd0;
`ifdef UART_RX_PARITY_EN
                    par_bad_r <= 1'b0;
`endif
                    if (rx_prev_r && !rx_sync_r) begin
                        state_r <= START;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                START: begin
                    if (sample_s) begin
                        state_r <= rx_sync_r ? IDLE : DATA;
                    end else begin
                        state_r <= START;
                    end
                end
                DATA: begin
                    if (sample_s) begin
                        shift_r   <= {rx_sync_r, shift_r[7:1]};
                        bit_cnt_r <= bit_cnt_r + 3'd1;
                        if (bit_cnt_r == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                            state_r <= PARITY;
`else
                            state_r <= STOP;
`endif
                        end else begin
                            state_r <= DATA;
                        end
                    end else begin
                        state_r <= DATA;
                    end
                end
`ifdef UART_RX_PARITY_EN
                PARITY: begin
                    if (sample_s) begin
                        par_bad_r <= (rx_sync_r != even_parity(shift_r));
                        state_r   <= STOP;
                    end else begin
                        state_r   <= PARITY;
                    end
                end
`endif
                STOP: begin
                    if (sample_s) begin
                        state_r <= IDLE;
                        if (!stop_ok_s) begin
                            frame_err  <= 1'b1;
                            byte_cnt_r <= 5'd0;
                        end else if (byte_cnt_r == 5'd0) begin
                            // Opcode byte must look like 101000ss, otherwise stay here to resync.
                            if (shift_r[7:2] == 6'b101000) begin
                                sel_sh_r   <= shift_r[1:0];
                                byte_cnt_r <= 5'd1;
                            end else begin
                                byte_cnt_r <= 5'd0;
                            end
                        end else if (byte_cnt_r <= 5'd8) begin
                            sh_a_r     <= {shift_r, sh_a_r[63:8]};
                            byte_cnt_r <= byte_cnt_r + 5'd1;
                        end else if (byte_cnt_r < 5'd16) begin
                            sh_b_r     <= {shift_r, sh_b_r[63:8]};
                            byte_cnt_r <= byte_cnt_r + 5'd1;
                        end else begin
                            op_sel     <= sel_sh_r;
                            op_a       <= sh_a_r;
                            op_b       <= {shift_r, sh_b_r[63:8]};
                            op_valid   <= 1'b1;
                            byte_cnt_r <= 5'd0;
                        end
                    end else begin
                        state_r <= STOP;
                    end
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end
endmodule
